// File: rtl/dmem_pkg.sv
// Shared types, funct3 encodings and access-legality check for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Unsigned widths exist only for loads; a simultaneous rd and wr is never legal.
  function automatic logic access_err(input logic [2:0] funct3,
                                      input logic [1:0] addr_lo,
                                      input logic       is_rd,
                                      input logic       is_wr);
    logic e;
    e = 1'b0;
    case (funct3)
      F3_B:    e = 1'b0;
      F3_H:    e = addr_lo[0];
      F3_W:    e = |addr_lo;
      F3_BU:   e = is_wr;
      F3_HU:   e = is_wr | addr_lo[0];
      default: e = 1'b1;
    endcase
    return e | (is_rd & is_wr);
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store byte-enables and replicated write word, load extraction and extension.
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        funct3,
  input  logic [1:0]        addr_lo,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] rd_word,
  output logic [3:0]        be,
  output logic [DATA_W-1:0] wr_word,
  output logic [DATA_W-1:0] ld_data
);

  function automatic logic [DATA_W-1:0] ext_byte(input logic signed [7:0] b, input logic sgn);
    return sgn ? {{(DATA_W-8){b[7]}}, b} : {{(DATA_W-8){1'b0}}, b};
  endfunction

  function automatic logic [DATA_W-1:0] ext_half(input logic signed [15:0] h, input logic sgn);
    return sgn ? {{(DATA_W-16){h[15]}}, h} : {{(DATA_W-16){1'b0}}, h};
  endfunction

  logic signed [7:0]  ld_byte;
  logic signed [15:0] ld_half;

  always_comb begin
    be      = 4'b0000;
    wr_word = wr_data;
    case (funct3)
      F3_B: begin
        be      = 4'b0001 << addr_lo;
        wr_word = {4{wr_data[7:0]}};
      end
      F3_H: begin
        be      = addr_lo[1] ? 4'b1100 : 4'b0011;
        wr_word = {2{wr_data[15:0]}};
      end
      F3_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  always_comb begin
    case (addr_lo)
      2'd0:    ld_byte = rd_word[7:0];
      2'd1:    ld_byte = rd_word[15:8];
      2'd2:    ld_byte = rd_word[23:16];
      default: ld_byte = rd_word[31:24];
    endcase
    ld_half = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];
    case (funct3)
      F3_B:    ld_data = ext_byte(ld_byte, 1'b1);
      F3_BU:   ld_data = ext_byte(ld_byte, 1'b0);
      F3_H:    ld_data = ext_half(ld_half, 1'b1);
      F3_HU:   ld_data = ext_half(ld_half, 1'b0);
      default: ld_data = rd_word;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: byte-addressed RAM behind an IDLE/WAIT/RESP handshake with
// programmable wait states, lane steering and local error detection.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 9,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        funct3,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              ready,
  output logic              err,
  output logic              busy
);

  localparam int         WORDS    = 2 ** (ADDR_W - 2);
  localparam logic [2:0] CNT_INIT = 3'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);

  state_t state_q, state_d;
  logic [2:0] cnt_q;

  logic [ADDR_W-1:0] addr_p0;
  logic [2:0]        funct3_p0;
  logic [DATA_W-1:0] wr_data_p0;
  logic              ld_p0, st_p0, err_p0;

  logic [DATA_W-1:0] mem [WORDS];

  logic              accept, enter_resp;
  logic [ADDR_W-1:0] sel_addr;
  logic [2:0]        sel_funct3;
  logic [DATA_W-1:0] sel_wr_data;
  logic              sel_ld, sel_st, sel_err;
  logic [3:0]        be;
  logic [DATA_W-1:0] wr_word, ld_data, rd_word;
  logic              mem_we;

  assign accept = (state_q == IDLE) && (rd || wr);
  assign enter_resp = (state_q == IDLE) ? (accept && (WAIT_CYCLES == 0))
                                        : ((state_q == WAIT) && (cnt_q == 3'd0));

  // With zero wait states the RAM access happens on the accept edge, so the live request is used.
  always_comb begin
    if (state_q == IDLE) begin
      sel_addr    = addr;
      sel_funct3  = funct3;
      sel_wr_data = wr_data;
      sel_ld      = rd;
      sel_st      = wr;
      sel_err     = access_err(funct3, addr[1:0], rd, wr);
    end else begin
      sel_addr    = addr_p0;
      sel_funct3  = funct3_p0;
      sel_wr_data = wr_data_p0;
      sel_ld      = ld_p0;
      sel_st      = st_p0;
      sel_err     = err_p0;
    end
  end

  assign rd_word = mem[sel_addr[ADDR_W-1:2]];
  assign mem_we  = enter_resp && sel_st && !sel_err && !reset;

  dmem_lane_align #(.DATA_W(DATA_W)) u_align (
    .funct3  (sel_funct3),
    .addr_lo (sel_addr[1:0]),
    .wr_data (sel_wr_data),
    .rd_word (rd_word),
    .be      (be),
    .wr_word (wr_word),
    .ld_data (ld_data)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT:    if (cnt_q == 3'd0) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready = (state_q == RESP);
    busy  = (state_q != IDLE);
    err   = ready && err_p0;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= 3'd0;
    else if (accept) cnt_q <= CNT_INIT;
    else if (state_q == WAIT && cnt_q != 3'd0) cnt_q <= cnt_q - 3'd1;
  end

  // Request capture at accept
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_p0    <= addr;
      funct3_p0  <= funct3;
      wr_data_p0 <= wr_data;
      ld_p0      <= rd;
      st_p0      <= wr;
      err_p0     <= access_err(funct3, addr[1:0], rd, wr);
    end
  end

  // Response stage: RAM update and load result land on the edge entering RESP
  always_ff @(posedge clk) begin
    if (reset) rd_data <= '0;
    else if (enter_resp && sel_ld) rd_data <= sel_err ? '0 : ld_data;
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[sel_addr[ADDR_W-1:2]][8*b +: 8] <= wr_word[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with one wait state, one with none.
module tb_dmem_responder;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd1, wr1, rd0, wr0;
  logic [8:0]  addr1, addr0;
  logic [2:0]  f31, f30;
  logic [31:0] wd1, wd0, rdd1, rdd0;
  logic        rdy1, err1, busy1, rdy0, err0, busy0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DATA_W(32), .ADDR_W(9), .WAIT_CYCLES(1)) dut (
    .clk(clk), .reset(reset), .rd(rd1), .wr(wr1), .addr(addr1), .funct3(f31),
    .wr_data(wd1), .rd_data(rdd1), .ready(rdy1), .err(err1), .busy(busy1));

  dmem_responder #(.DATA_W(32), .ADDR_W(9), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .rd(rd0), .wr(wr0), .addr(addr0), .funct3(f30),
    .wr_data(wd0), .rd_data(rdd0), .ready(rdy0), .err(err0), .busy(busy0));

  // Issues one request (sel=1 -> dut, sel=0 -> dut0), waits for ready with a bound.
  // lat counts clock edges from presenting the request to the cycle ready is seen.
  task automatic do_req(input bit sel, input logic r, input logic w, input logic [2:0] f3,
                        input logic [8:0] a, input logic [31:0] d,
                        output logic [31:0] q, output logic e, output int lat,
                        output logic busy_acc);
    logic rdy;
    if (sel) begin rd1 = r; wr1 = w; f31 = f3; addr1 = a; wd1 = d; end
    else     begin rd0 = r; wr0 = w; f30 = f3; addr0 = a; wd0 = d; end
    @(posedge clk); #1;
    lat = 1;
    if (sel) begin rd1 = 1'b0; wr1 = 1'b0; busy_acc = busy1; end
    else     begin rd0 = 1'b0; wr0 = 1'b0; busy_acc = busy0; end
    rdy = sel ? rdy1 : rdy0;
    while (!rdy && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      rdy = sel ? rdy1 : rdy0;
    end
    q = sel ? rdd1 : rdd0;
    e = sel ? err1 : err0;
    n_cmp++;
    if (!rdy) begin
      n_bad++;
      $display("FAIL req_timeout: ready not seen within %0d cycles, required within 20", lat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rd1 = 0; wr1 = 0; f31 = F3_W; addr1 = '0; wd1 = '0;
    rd0 = 0; wr0 = 0; f30 = F3_W; addr0 = '0; wd0 = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    n_cmp++; if (rdy1 !== 1'b0)    begin n_bad++; $display("FAIL rst_ready: got %b want 0", rdy1); end
    n_cmp++; if (err1 !== 1'b0)    begin n_bad++; $display("FAIL rst_err: got %b want 0", err1); end
    n_cmp++; if (busy1 !== 1'b0)   begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy1); end
    n_cmp++; if (rdd1 !== 32'h0)   begin n_bad++; $display("FAIL rst_rd_data: got %h want 0", rdd1); end
    n_cmp++; if ({rdy0, err0, busy0} !== 3'b000 || rdd0 !== 32'h0) begin
      n_bad++; $display("FAIL rst_dut0: got rdy/err/busy=%b%b%b data=%h want 000/0", rdy0, err0, busy0, rdd0);
    end
  endtask

  task automatic test_sw_lw();
    logic [31:0] q; logic e, b; int lat;
    do_req(1, 0, 1, F3_W, 9'h010, 32'h12345678, q, e, lat, b);
    n_cmp++; if (lat != 2) begin n_bad++; $display("FAIL sw_latency: got %0d want 2", lat); end
    n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL sw_err: got %b want 0", e); end
    n_cmp++; if (b !== 1'b1) begin n_bad++; $display("FAIL sw_busy_wait: got %b want 1", b); end
    do_req(1, 1, 0, F3_W, 9'h010, 32'h0, q, e, lat, b);
    n_cmp++; if (q !== 32'h12345678 || e !== 1'b0) begin
      n_bad++; $display("FAIL lw_data: got %h err %b want 12345678 err 0", q, e);
    end
  endtask

  task automatic test_lanes();
    logic [31:0] q; logic e, b; int lat;
    do_req(1, 0, 1, F3_B, 9'h013, 32'h000000AB, q, e, lat, b);
    do_req(1, 1, 0, F3_W, 9'h010, 32'h0, q, e, lat, b);
    n_cmp++; if (q !== 32'hAB345678) begin n_bad++; $display("FAIL sb_word: got %h want ab345678", q); end
    do_req(1, 1, 0, F3_B, 9'h013, 32'h0, q, e, lat, b);
    n_cmp++; if (q !== 32'hFFFFFFAB) begin n_bad++; $display("FAIL lb: got %h want ffffffab", q); end
    do_req(1, 1, 0, F3_BU, 9'h013, 32'h0, q, e, lat, b);
    n_cmp++; if (q !== 32'h000000AB) begin n_bad++; $display("FAIL lbu: got %h want 000000ab", q); end
    do_req(1, 1, 0, F3_H, 9'h012, 32'h0, q, e, lat, b);
    n_cmp++; if (q !== 32'hFFFFAB34) begin n_bad++; $display("FAIL lh: got %h want ffffab34", q); end
    do_req(1, 1, 0, F3_HU, 9'h010, 32'h0, q, e, lat, b);
    n_cmp++; if (q !== 32'h00005678) begin n_bad++; $display("FAIL lhu: got %h want 00005678", q); end
    do_req(1, 0, 1, F3_H, 9'h010, 32'hFFFF9ABC, q, e, lat, b);
    do_req(1, 1, 0, F3_W, 9'h010, 32'h0, q, e, lat, b);
    n_cmp++; if (q !== 32'hAB349ABC) begin n_bad++; $display("FAIL sh_word: got %h want ab349abc", q); end
    do_req(1, 1, 0, F3_H, 9'h010, 32'h0, q, e, lat, b);
    n_cmp++; if (q !== 32'hFFFF9ABC) begin n_bad++; $display("FAIL lh_low: got %h want ffff9abc", q); end
  endtask

  task automatic test_misalign();
    logic [31:0] q; logic e, b; int lat;
    do_req(1, 1, 0, F3_W, 9'h011, 32'h0, q, e, lat, b);
    n_cmp++; if (e !== 1'b1 || q !== 32'h0) begin
      n_bad++; $display("FAIL lw_misalign: got err %b data %h want err 1 data 0", e, q);
    end
    do_req(1, 0, 1, F3_W, 9'h014, 32'h0BADF00D, q, e, lat, b);
    do_req(1, 1, 0, F3_W, 9'h014, 32'h0, q, e, lat, b);
    do_req(1, 0, 1, F3_H, 9'h015, 32'h00001234, q, e, lat, b);
    n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL sh_misalign_err: got %b want 1", e); end
    n_cmp++; if (q !== 32'h0BADF00D) begin n_bad++; $display("FAIL store_err_keeps_rd_data: got %h want 0badf00d", q); end
    do_req(1, 1, 0, F3_W, 9'h014, 32'h0, q, e, lat, b);
    n_cmp++; if (q !== 32'h0BADF00D) begin n_bad++; $display("FAIL sh_misalign_ram: got %h want 0badf00d", q); end
    do_req(1, 1, 0, 3'b011, 9'h010, 32'h0, q, e, lat, b);
    n_cmp++; if (e !== 1'b1 || q !== 32'h0) begin
      n_bad++; $display("FAIL f3_011: got err %b data %h want err 1 data 0", e, q);
    end
    do_req(1, 0, 1, F3_BU, 9'h010, 32'h0, q, e, lat, b);
    n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL store_bu_err: got %b want 1", e); end
    do_req(1, 1, 0, F3_W, 9'h010, 32'h0, q, e, lat, b);
    n_cmp++; if (q !== 32'hAB349ABC || e !== 1'b0) begin
      n_bad++; $display("FAIL store_bu_ram: got %h err %b want ab349abc err 0", q, e);
    end
  endtask

  task automatic test_rd_wr_both();
    logic [31:0] q; logic e, b; int lat;
    do_req(1, 0, 1, F3_W, 9'h020, 32'h600DCAFE, q, e, lat, b);
    do_req(1, 1, 1, F3_W, 9'h020, 32'hFFFFFFFF, q, e, lat, b);
    n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL rdwr_err: got %b want 1", e); end
    do_req(1, 1, 0, F3_W, 9'h020, 32'h0, q, e, lat, b);
    n_cmp++; if (q !== 32'h600DCAFE) begin n_bad++; $display("FAIL rdwr_ram: got %h want 600dcafe", q); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] q; logic e, b; int lat;
    do_req(1, 0, 1, F3_W, 9'h040, 32'hDEADBEEF, q, e, lat, b);
    do_req(1, 1, 0, F3_W, 9'h040, 32'h0, q, e, lat, b);
    rd1 = 0; wr1 = 1; f31 = F3_W; addr1 = 9'h040; wd1 = 32'h11111111;
    @(posedge clk); #1;
    wr1 = 0;
    n_cmp++; if (busy1 !== 1'b1 || rdy1 !== 1'b0) begin
      n_bad++; $display("FAIL abort_in_wait: got busy %b ready %b want 1 0", busy1, rdy1);
    end
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    n_cmp++; if ({rdy1, err1, busy1} !== 3'b000 || rdd1 !== 32'h0) begin
      n_bad++; $display("FAIL abort_outputs: got rdy/err/busy=%b%b%b data=%h want 000/0", rdy1, err1, busy1, rdd1);
    end
    do_req(1, 1, 0, F3_W, 9'h040, 32'h0, q, e, lat, b);
    n_cmp++; if (q !== 32'hDEADBEEF) begin n_bad++; $display("FAIL abort_ram: got %h want deadbeef", q); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] q; logic e, b; int lat;
    logic exp_rdy;
    do_req(0, 0, 1, F3_W, 9'h010, 32'hCAFEF00D, q, e, lat, b);
    n_cmp++; if (lat != 1 || b !== 1'b1) begin
      n_bad++; $display("FAIL w0_latency: got lat %0d busy %b want 1 1", lat, b);
    end
    do_req(0, 0, 1, F3_W, 9'h020, 32'h55AA55AA, q, e, lat, b);
    rd0 = 1; wr0 = 0; f30 = F3_W; addr0 = 9'h010;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      exp_rdy = (i % 2 == 0);
      n_cmp++; if (rdy0 !== exp_rdy || busy0 !== exp_rdy) begin
        n_bad++; $display("FAIL b2b_ready[%0d]: got ready %b busy %b want %b", i, rdy0, busy0, exp_rdy);
      end
      if (exp_rdy) begin
        n_cmp++; if (rdd0 !== 32'hCAFEF00D) begin
          n_bad++; $display("FAIL b2b_data[%0d]: got %h want cafef00d", i, rdd0);
        end
      end
      addr0 = exp_rdy ? 9'h020 : 9'h010;
    end
    rd0 = 0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_sw_lw();
    test_lanes();
    test_misalign();
    test_rd_wr_both();
    test_reset_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
